// File: rtl/traffic_pkg.sv
// Shared phase encodings and config-select codes for the traffic-light time base.
package traffic_pkg;

  localparam logic [2:0] PH_G    = 3'b100;
  localparam logic [2:0] PH_Y    = 3'b010;
  localparam logic [2:0] PH_R    = 3'b001;
  localparam logic [2:0] PH_NONE = 3'b000;

  typedef enum logic [1:0] {
    CFG_SEL_G   = 2'd0,
    CFG_SEL_Y   = 2'd1,
    CFG_SEL_R   = 2'd2,
    CFG_SEL_PED = 2'd3
  } cfg_sel_e;

  function automatic logic phase_valid(input logic [2:0] p);
    return (p == PH_G) || (p == PH_Y) || (p == PH_R);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            W    = $clog2(TICK_DIV);
  localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;

  // Clear wins over enable so a phase entry never produces a tick.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/phase_timer_ctrl.sv
// Times each traffic-light phase from programmable durations and pulses end-of-phase
// strobes back to the FSM; also handles pedestrian green shortening and countdown export.
module phase_timer_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8,
  parameter int DUR_G    = 30,
  parameter int DUR_Y    = 3,
  parameter int DUR_R    = 2,
  parameter int PED_MIN  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fsm_g,
  input  logic             fsm_y,
  input  logic             fsm_r,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             ped_req,
  output logic             g_end,
  output logic             y_end,
  output logic             r_end,
  output logic             ped_ack,
  output logic [CNT_W-1:0] remain
);

  logic [2:0]       phase;
  logic             valid, entry, live, fire, clamp, tick;
  logic [CNT_W-1:0] entry_dur, dur_wdata;

  logic [2:0]       prev_phase_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_g_q, dur_g_d, dur_y_q, dur_y_d, dur_r_q, dur_r_d;
  logic [CNT_W-1:0] ped_min_q, ped_min_d;
  logic             done_q, done_d, ped_pend_q, ped_pend_d;
  logic             g_end_q, g_end_d, y_end_q, y_end_d, r_end_q, r_end_d;
  logic             ped_ack_q, ped_ack_d;
  logic [CNT_W-1:0] remain_q;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry),
    .en   (valid & ~done_q),
    .tick (tick)
  );

  always_comb begin
    phase = {fsm_g, fsm_y, fsm_r};
    valid = phase_valid(phase);
    entry = valid && (phase != prev_phase_q);
    live  = valid && !entry && !done_q;
    fire  = live && (cnt_q == '0);
    clamp = live && (phase == PH_G) && ped_pend_q;

    unique case (phase)
      PH_G:    entry_dur = dur_g_q;
      PH_Y:    entry_dur = dur_y_q;
      default: entry_dur = dur_r_q;
    endcase

    // A zero duration would end the phase without any tick, so it is stored as 1.
    dur_wdata = (cfg_data == '0) ? CNT_W'(1) : cfg_data;
    dur_g_d   = dur_g_q;
    dur_y_d   = dur_y_q;
    dur_r_d   = dur_r_q;
    ped_min_d = ped_min_q;
    if (cfg_we) begin
      unique case (cfg_sel_e'(cfg_sel))
        CFG_SEL_G:   dur_g_d   = dur_wdata;
        CFG_SEL_Y:   dur_y_d   = dur_wdata;
        CFG_SEL_R:   dur_r_d   = dur_wdata;
        CFG_SEL_PED: ped_min_d = cfg_data;
        default:     ped_min_d = ped_min_q;
      endcase
    end

    cnt_d = cnt_q;
    if (entry)                              cnt_d = entry_dur;
    else if (clamp && (cnt_q > ped_min_q))  cnt_d = ped_min_q;
    else if (tick && (cnt_q != '0))         cnt_d = cnt_q - 1'b1;

    done_d     = entry ? 1'b0 : (fire ? 1'b1 : done_q);
    ped_pend_d = clamp ? 1'b0 : (ped_req ? 1'b1 : ped_pend_q);
    ped_ack_d  = clamp;
    g_end_d    = fire && (phase == PH_G);
    y_end_d    = fire && (phase == PH_Y);
    r_end_d    = fire && (phase == PH_R);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase_q <= PH_NONE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      ped_pend_q   <= 1'b0;
      dur_g_q      <= CNT_W'(DUR_G);
      dur_y_q      <= CNT_W'(DUR_Y);
      dur_r_q      <= CNT_W'(DUR_R);
      ped_min_q    <= CNT_W'(PED_MIN);
      g_end_q      <= 1'b0;
      y_end_q      <= 1'b0;
      r_end_q      <= 1'b0;
      ped_ack_q    <= 1'b0;
      remain_q     <= '0;
    end else begin
      prev_phase_q <= phase;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      ped_pend_q   <= ped_pend_d;
      dur_g_q      <= dur_g_d;
      dur_y_q      <= dur_y_d;
      dur_r_q      <= dur_r_d;
      ped_min_q    <= ped_min_d;
      g_end_q      <= g_end_d;
      y_end_q      <= y_end_d;
      r_end_q      <= r_end_d;
      ped_ack_q    <= ped_ack_d;
      remain_q     <= cnt_d;
    end
  end

  assign g_end   = g_end_q;
  assign y_end   = y_end_q;
  assign r_end   = r_end_q;
  assign ped_ack = ped_ack_q;
  assign remain  = remain_q;

endmodule
